// File: rtl/fnd_bcd_counter_if.sv
// Control and display bus of the four-digit BCD counter feeding the FND scan mux.
// seg_out[i] is the active-low pattern for digit i; digit 0 is the ones digit.
interface fnd_bcd_counter_if;
  logic            en;
  logic            up_dn;
  logic            clr;
  logic            load;
  logic [15:0]     load_val;
  logic [15:0]     bcd_out;
  logic [3:0][7:0] seg_out;
  logic            wrap;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  bcd_out, seg_out, wrap
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output bcd_out, seg_out, wrap
  );
endinterface

// File: rtl/fnd_bcd_counter.sv
// Four-digit BCD up/down counter with prescaled count tick and a registered
// active-low 7-segment encoder (optional leading-zero blanking).
module fnd_bcd_counter #(
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter bit          LZ_BLANK = 1'b0
) (
  input logic              clk_wiz,
  input logic              rst,
  fnd_bcd_counter_if.slave bus
);

  localparam logic [23:0] PCNT_MAX = 24'(TICK_DIV - 1);

  logic [23:0]     pcnt;
  logic            step;
  logic [3:0][3:0] bcd_q;
  logic [3:0][3:0] bcd_step;
  logic            carry_out;
  logic            wrap_q;
  logic [3:0][7:0] seg_q;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  // Digit 0 is always shown; higher digits blank while they and all above are zero.
  function automatic logic [3:0][7:0] seg_map(input logic [15:0] v);
    logic [3:0][7:0] m;
    logic            lead;
    lead = 1'b1;
    m    = '1;
    for (int i = 3; i >= 1; i--) begin
      lead = lead && (v[4*i +: 4] == 4'd0);
      m[i] = (LZ_BLANK && lead) ? 8'hFF : seg_code(v[4*i +: 4]);
    end
    m[0] = seg_code(v[3:0]);
    return m;
  endfunction

  function automatic logic [15:0] sanitize(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

  assign step = bus.en && (pcnt == PCNT_MAX);

  always_ff @(posedge clk_wiz or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (bus.clr || bus.load || step) begin
      pcnt <= '0;
    end else if (bus.en) begin
      pcnt <= pcnt + 24'd1;
    end
  end

  // Ripple carry/borrow through the digits; surviving carry means a full wrap.
  always_comb begin
    bcd_step  = bcd_q;
    carry_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry_out) begin
        if (bus.up_dn) begin
          if (bcd_q[i] == 4'd9) begin
            bcd_step[i] = 4'd0;
          end else begin
            bcd_step[i] = bcd_q[i] + 4'd1;
            carry_out   = 1'b0;
          end
        end else begin
          if (bcd_q[i] == 4'd0) begin
            bcd_step[i] = 4'd9;
          end else begin
            bcd_step[i] = bcd_q[i] - 4'd1;
            carry_out   = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_wiz or negedge rst) begin
    if (!rst) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.clr) begin
        bcd_q <= '0;
      end else if (bus.load) begin
        bcd_q <= sanitize(bus.load_val);
      end else if (step) begin
        bcd_q  <= bcd_step;
        wrap_q <= carry_out;
      end
    end
  end

  always_ff @(posedge clk_wiz or negedge rst) begin
    if (!rst) begin
      seg_q <= seg_map(16'h0000);
    end else begin
      seg_q <= seg_map(bcd_q);
    end
  end

  assign bus.bcd_out = bcd_q;
  assign bus.seg_out = seg_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_fnd_bcd_counter.sv
// Directed bench: stimulus pushes expected count events, a negedge monitor
// pops and compares value, wrap and arrival cycle, then the segments a cycle later.
`timescale 1ns/1ps
module tb_fnd_bcd_counter;

  typedef struct {
    logic [15:0] bcd;
    logic        w;
    int          cyc;
  } exp_t;

  logic clk_wiz = 1'b0;
  logic rst     = 1'b1;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  exp_t q[$];

  fnd_bcd_counter_if bus0();
  fnd_bcd_counter_if bus1();

  fnd_bcd_counter #(.TICK_DIV(4), .LZ_BLANK(1'b0)) dut0 (
    .clk_wiz(clk_wiz), .rst(rst), .bus(bus0)
  );
  fnd_bcd_counter #(.TICK_DIV(4), .LZ_BLANK(1'b1)) dut1 (
    .clk_wiz(clk_wiz), .rst(rst), .bus(bus1)
  );

  always #100 clk_wiz = ~clk_wiz;
  always @(posedge clk_wiz) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [31:0] segs_of(input logic [15:0] b);
    return {enc(b[15:12]), enc(b[11:8]), enc(b[7:4]), enc(b[3:0])};
  endfunction

  // Monitor: an event is any bcd_out change or a wrap pulse on dut0.
  initial begin
    logic [15:0] prev;
    logic [31:0] seg_exp;
    logic        seg_pend;
    exp_t        e;
    prev     = '0;
    seg_exp  = '0;
    seg_pend = 1'b0;
    forever begin
      @(negedge clk_wiz);
      if (!rst) begin
        prev     = bus0.bcd_out;
        seg_pend = 1'b0;
      end else begin
        if (seg_pend) begin
          chk("seg_out", bus0.seg_out, seg_exp);
          seg_pend = 1'b0;
        end
        if (bus0.bcd_out !== prev || bus0.wrap !== 1'b0) begin
          if (q.size() == 0) begin
            chk("unexpected_event", {15'd0, bus0.wrap, bus0.bcd_out}, {16'd0, prev});
          end else begin
            e = q.pop_front();
            chk("bcd_out", bus0.bcd_out, e.bcd);
            chk("wrap", bus0.wrap, e.w);
            chk("event_cycle", cyc, e.cyc);
            seg_exp  = segs_of(e.bcd);
            seg_pend = 1'b1;
          end
        end
        prev = bus0.bcd_out;
      end
    end
  end

  task automatic push(input logic [15:0] b, input logic w, input int c);
    exp_t e;
    e.bcd = b;
    e.w   = w;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_wiz);
  endtask

  task automatic load0(input logic [15:0] v, input logic [15:0] exp);
    bus0.load     = 1'b1;
    bus0.load_val = v;
    push(exp, 1'b0, cyc + 1);
    tick(1);
    bus0.load = 1'b0;
  endtask

  // Called right after the prescaler restarted; the step lands 4 edges later.
  task automatic step0(input logic [15:0] exp, input logic w);
    push(exp, w, cyc + 4);
    tick(4);
  endtask

  task automatic load1(input logic [15:0] v, input logic [31:0] seg);
    bus1.load     = 1'b1;
    bus1.load_val = v;
    tick(1);
    bus1.load = 1'b0;
    tick(1);
    chk("lz_bcd", bus1.bcd_out, v);
    chk("lz_seg", bus1.seg_out, seg);
  endtask

  initial begin
    bus0.en = 1'b0; bus0.up_dn = 1'b1; bus0.clr = 1'b0; bus0.load = 1'b0; bus0.load_val = '0;
    bus1.en = 1'b0; bus1.up_dn = 1'b1; bus1.clr = 1'b0; bus1.load = 1'b0; bus1.load_val = '0;
    #5 rst = 1'b0;
    tick(2);
    chk("rst_bcd", bus0.bcd_out, 32'h0);
    chk("rst_seg", bus0.seg_out, 32'hC0C0C0C0);
    chk("rst_wrap", bus0.wrap, 32'h0);
    chk("rst_lz_seg", bus1.seg_out, 32'hFFFFFFC0);

    rst     = 1'b1;
    bus0.en = 1'b1;
    step0(16'h0001, 1'b0);

    load0(16'h0999, 16'h0999);
    step0(16'h1000, 1'b0);
    load0(16'h9999, 16'h9999);
    step0(16'h0000, 1'b1);

    bus0.up_dn = 1'b0;
    load0(16'h1000, 16'h1000);
    step0(16'h0999, 1'b0);
    load0(16'h0000, 16'h0000);
    step0(16'h9999, 1'b1);
    load0(16'hA5F3, 16'h0503);
    step0(16'h0502, 1'b0);

    // clr and load together on a due step from 9999: clr wins, no wrap.
    load0(16'h9999, 16'h9999);
    tick(3);
    bus0.clr      = 1'b1;
    bus0.load     = 1'b1;
    bus0.load_val = 16'h1234;
    bus0.up_dn    = 1'b1;
    push(16'h0000, 1'b0, cyc + 1);
    tick(1);
    bus0.clr  = 1'b0;
    bus0.load = 1'b0;
    step0(16'h0001, 1'b0);

    // clr mid-interval restarts the prescaler.
    tick(2);
    bus0.clr = 1'b1;
    push(16'h0000, 1'b0, cyc + 1);
    tick(1);
    bus0.clr = 1'b0;
    step0(16'h0001, 1'b0);

    load0(16'h8765, 16'h8765);
    step0(16'h8766, 1'b0);
    push(16'h8767, 1'b0, cyc + 7);
    tick(1);
    bus0.en = 1'b0;
    tick(3);
    bus0.en = 1'b1;
    tick(3);
    bus0.en = 1'b0;
    tick(2);

    load1(16'h0042, 32'hFFFF99A4);
    load1(16'h0000, 32'hFFFFFFC0);
    load1(16'h0105, 32'hFFF9C092);
    load1(16'h1000, 32'hF9C0C0C0);
    load1(16'h0041, 32'hFFFF99F9);
    bus1.en = 1'b1;
    tick(5);
    chk("lz_step_bcd", bus1.bcd_out, 32'h0042);
    chk("lz_step_seg", bus1.seg_out, 32'hFFFF99A4);
    chk("queue_drained", q.size(), 32'd0);

    bus0.en = 1'b1;
    tick(2);
    @(posedge clk_wiz);
    #50 rst = 1'b0;
    #1;
    chk("async_rst_bcd", bus0.bcd_out, 32'h0);
    chk("async_rst_seg", bus0.seg_out, 32'hC0C0C0C0);
    chk("async_rst_wrap", bus0.wrap, 32'h0);
    chk("async_rst_lz_bcd", bus1.bcd_out, 32'h0);
    chk("async_rst_lz_seg", bus1.seg_out, 32'hFFFFFFC0);
    tick(2);
    rst = 1'b1;
    push(16'h0001, 1'b0, cyc + 4);
    tick(6);
    chk("final_queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_bcd_counter.md
# fnd_bcd_counter

Four-digit decimal up/down counter with an integrated 7-segment encoder; it is the stage directly upstream of the FND scan multiplexer. It divides the 5 MHz clk_wiz domain down to a count tick, maintains four BCD digits with wrap and load/clear control, and presents one registered active-low segment pattern per digit. The scan multiplexer consumes these patterns directly.

## Interface
- TICK_DIV, 5_000_000: clk_wiz cycles per count step; the default gives 1 Hz at 5 MHz. Legal range is 2..2^24.
- LZ_BLANK, 0: when 1, leading-zero digits are blanked; digit 0 is never blanked.
- clk_wiz  in  1  system clock, 5 MHz; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  count enable; the prescaler advances only while 1.
- up_dn  in  1  direction: 1 = up, 0 = down; sampled at each step.
- clr  in  1  synchronous clear to 0000.
- load  in  1  synchronous load of load_val.
- load_val  in  16  BCD value; [3:0] = digit 0 (ones), [15:12] = digit 3.
- bcd_out  out  16  current count in BCD, same nibble order as load_val.
- seg_out  out  8 x [0:3]  segment pattern per digit; seg_out[0] = ones digit.
- wrap  out  1  one-cycle pulse when the count wraps.

## Operation
- Segment encoding (active-low):
  - bit7 = dp, always 1 (off); bits6:0 = g..a.
  - Codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
- Prescaler:
  - 24-bit counter pcnt, counts 0..TICK_DIV-1.
  - When en=1 and pcnt==TICK_DIV-1: pcnt goes to 0 and step=1 for that cycle.
  - When en=0: pcnt holds its value.
- Priority each cycle: clr > load > step.
  - clr: bcd_out=0000, pcnt=0, no wrap.
  - load: each nibble of load_val is taken as-is if <=9, otherwise replaced by 0; pcnt=0; no wrap.
- Up step:
  - Digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - 9999 goes to 0000 with wrap=1.
- Down step:
  - Digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
  - 0000 goes to 9999 with wrap=1.
- Decode: seg_out[i] = code(bcd digit i).
- Blanking, when LZ_BLANK=1:
  - Digit i (i=3..1) shows FF if it and every higher digit are 0.
  - Example: 0042 displays as FF FF 99 A4 (digit3..digit0).
- There are no invalid BCD states internally. The decoder maps any nibble >9 to FF as a defensive default.

## Timing
- Reset values (rst=0, asynchronous):
  - pcnt=0, bcd_out=0000, wrap=0.
  - seg_out = C0 on all digits when LZ_BLANK=0.
  - seg_out = FF, FF, FF, C0 (digit3..0) when LZ_BLANK=1.
- Release: the first step can occur no earlier than TICK_DIV cycles after rst rises with en=1.
- bcd_out and wrap update on the same edge as step, clr or load.
- seg_out is registered and updates one clk_wiz cycle after bcd_out (latency 1).
- wrap is high for exactly one cycle, coincident with bcd_out changing to the wrapped value.
- Steps are spaced exactly TICK_DIV cycles apart while en is held at 1. Pausing en stretches the interval by the number of en=0 cycles.
- clr or load asserted on the step cycle: clr/load wins, and the step is discarded.
- clr and load asserted together: clr wins.
- up_dn changing between steps takes effect at the next step. There is no glitch on bcd_out.
- Reset asserted mid-count: all state returns to reset values immediately, regardless of clock.

## Test plan
- Reset, TICK_DIV=4, LZ_BLANK=0 -> bcd_out=0000, seg_out all C0, wrap=0. Release with en=1 -> bcd_out=0001 on the 4th edge, seg_out[0]=F9 one cycle later.
- Carry chain: load 0999 then step up -> bcd_out=1000, seg_out = F9, C0, C0, C0 (digit3..0), wrap=0. Load 9999 then step up -> 0000 with a single-cycle wrap.
- Borrow: load 1000, up_dn=0, step -> 0999. Load 0000, step down -> 9999 with wrap=1 for one cycle.
- Load sanitising: load_val=16'hA5F3 -> bcd_out=0503. Assert clr and load together with a step due -> bcd_out=0000, no wrap, and the next step occurs 4 cycles later.
- en pause: drop en for 3 cycles mid-interval -> the step arrives 7 cycles after the previous one, not 4.
- LZ_BLANK=1: count 0042 -> seg_out = FF, FF, 99, A4. Value 0000 -> FF, FF, FF, C0. Asynchronous reset mid-interval -> outputs return to reset values before the next clock edge.
